// File: rtl/mdu_ctrl.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiplier, restoring divider, one bit per cycle.
// Optional build macro MDU_ZERO_SKIP_EN: trivial operands (zero multiply operand, zero divisor) bypass CALC.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, acc_r, q_r, hi_r, lo_r;
  logic [CW-1:0]      cnt_r;
  logic               neg_q_r, neg_r_r, zero_mul_r, div_zero_r, done_r;
  logic               is_div_s, is_signed_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, res_hi_s, res_lo_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      abs_val = {WIDTH{1'b0}} - v;
    end else begin
      abs_val = v;
    end
  endfunction

  assign is_div_s    = op_r[1];
  assign is_signed_s = ~op_r[0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush wins everywhere, including over start in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!flush && start) state_s = S_PREP;
        else                 state_s = S_IDLE;
      end
      S_PREP: begin
        if (flush) begin
          state_s = S_IDLE;
        end else begin
`ifdef MDU_ZERO_SKIP_EN
          if ((b_r == {WIDTH{1'b0}}) || (!is_div_s && (a_r == {WIDTH{1'b0}}))) state_s = S_FIX;
          else                                                                  state_s = S_CALC;
`else
          state_s = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush)                          state_s = S_IDLE;
        else if (cnt_r == CW'(WIDTH - 1))   state_s = S_FIX;
        else                                state_s = S_CALC;
      end
      S_FIX:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy      = (state_r != S_IDLE);
    stall_req = (state_r != S_IDLE) & (start | mf_req | mt_hi | mt_lo);
  end

  // Per-iteration datapath and final sign correction
  always_comb begin
    mul_sum_s   = {1'b0, acc_r} + (q_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r, q_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    prod_s      = neg_q_r ? ({(2*WIDTH){1'b0}} - {acc_r, q_r}) : {acc_r, q_r};
    quot_s      = neg_q_r ? ({WIDTH{1'b0}} - q_r) : q_r;
    rem_s       = neg_r_r ? ({WIDTH{1'b0}} - acc_r) : acc_r;
    if (is_div_s) begin
      if (div_zero_r) begin
        res_hi_s = a_r;
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_hi_s = rem_s;
        res_lo_s = quot_s;
      end
    end else begin
      if (zero_mul_r) begin
        res_hi_s = {WIDTH{1'b0}};
        res_lo_s = {WIDTH{1'b0}};
      end else begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
      end
    end
  end

  // Operand capture, iteration registers and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r       <= 2'd0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      q_r        <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      zero_mul_r <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (!flush && start) begin
            op_r <= op;
            a_r  <= rs_data;
            b_r  <= rt_data;
          end
          if (mt_hi) hi_r <= rt_data;
          if (mt_lo) lo_r <= rt_data;
        end
        S_PREP: begin
          acc_r      <= {WIDTH{1'b0}};
          cnt_r      <= {CW{1'b0}};
          q_r        <= abs_val(a_r, is_signed_s);
          b_r        <= abs_val(b_r, is_signed_s);
          neg_q_r    <= is_signed_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r_r    <= is_signed_s & a_r[WIDTH-1];
          zero_mul_r <= (a_r == {WIDTH{1'b0}}) || (b_r == {WIDTH{1'b0}});
          div_zero_r <= (b_r == {WIDTH{1'b0}});
        end
        S_CALC: begin
          cnt_r <= cnt_r + CW'(1);
          if (is_div_s) begin
            if (!div_diff_s[WIDTH]) begin
              acc_r <= div_diff_s[WIDTH-1:0];
              q_r   <= {q_r[WIDTH-2:0], 1'b1};
            end else begin
              acc_r <= div_shift_s[WIDTH-1:0];
              q_r   <= {q_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_r <= mul_sum_s[WIDTH:1];
            q_r   <= {mul_sum_s[0], q_r[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
